// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_if
// Brief    : Memory-read and decoder/controller signals of the fetch stage.
// Revision : 1.0
// ============================================================================
interface instruction_fetch_if #(
  parameter int ADDR_W = 9
);
  logic [15:0]       mem_rdata;
  logic              mem_ready;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       ir_out;
  logic              ir_valid;
  logic              exec_done;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              halt;
  logic [ADDR_W-1:0] pc_out;
  logic [15:0]       instr_count;

  modport master (
    input  mem_rdata, mem_ready, exec_done, branch_taken, branch_target,
    output mem_read, mem_addr, ir_out, ir_valid, halt, pc_out, instr_count
  );

  modport slave (
    output mem_rdata, mem_ready, exec_done, branch_taken, branch_target,
    input  mem_read, mem_addr, ir_out, ir_valid, halt, pc_out, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : Fetch stage owning PC and IR; feeds the instruction decoder.
//            FETCH_INSTR_COUNT_EN enables the saturating retired-instruction
//            counter on instr_count (tied to zero otherwise).
// Revision : 1.0
// ============================================================================
module instruction_fetch #(
  parameter int                ADDR_W   = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  instruction_fetch_if.master  bus
);

  localparam logic [2:0] S_RESET = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_ir;
  logic              w_mem_read;
  logic              w_ir_valid;
  logic              w_halt;
  logic              w_load;
  logic              w_retire;

  assign w_load   = (r_state == S_WAIT) && bus.mem_ready;
  assign w_retire = (r_state == S_HOLD) && bus.exec_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RESET: w_next_state = S_FETCH;
      S_FETCH: w_next_state = S_WAIT;
      S_WAIT: begin
        if (bus.mem_ready) begin
          w_next_state = (bus.mem_rdata[15:13] == 3'b111) ? S_HALT : S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.exec_done) begin
          w_next_state = S_FETCH;
        end
      end
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_RESET;
    endcase
  end

  always_comb begin
    w_mem_read = 1'b0;
    w_ir_valid = 1'b0;
    w_halt     = 1'b0;
    case (r_state)
      S_FETCH: w_mem_read = 1'b1;
      S_WAIT:  w_mem_read = 1'b1;
      S_HOLD:  w_ir_valid = 1'b1;
      S_HALT: begin
        w_ir_valid = 1'b1;
        w_halt     = 1'b1;
      end
      default: ;
    endcase
  end

  // PC advances at IR load, so a taken branch simply overrides the increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
      r_ir <= 16'h0000;
    end else if (w_load) begin
      r_ir <= bus.mem_rdata;
      r_pc <= r_pc + ADDR_W'(1);
    end else if (w_retire && bus.branch_taken) begin
      r_pc <= bus.branch_target;
    end
  end

`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] r_instr_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr_count <= 16'h0000;
    end else if (w_retire && (r_instr_count != 16'hFFFF)) begin
      r_instr_count <= r_instr_count + 16'd1;
    end
  end

  assign bus.instr_count = r_instr_count;
`else
  assign bus.instr_count = 16'h0000;
`endif

  assign bus.mem_read = w_mem_read;
  assign bus.mem_addr = r_pc;
  assign bus.ir_out   = r_ir;
  assign bus.ir_valid = w_ir_valid;
  assign bus.halt     = w_halt;
  assign bus.pc_out   = r_pc;

endmodule
`default_nettype wire
